// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state encoding and digit width for the binary-to-BCD
// converter and the downstream Excess-3 stage.
package bcd_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_e;

endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// Valid/ready bundle between a binary producer and the serial BCD converter;
// master is the producer/consumer side, slave is the converter.
interface bin_to_bcd_serial_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  busy;

   modport master (
      output in_valid, bin_in, out_ready,
      input  in_ready, out_valid, bcd_out, busy
   );

   modport slave (
      input  in_valid, bin_in, out_ready,
      output in_ready, out_valid, bcd_out, busy
   );
endinterface

// File: rtl/bin_to_bcd_serial_add3.sv
// One BCD digit correction step of shift-and-add-3: adds 3 when the digit is 5 or more.
// Purely combinational, no handshake.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] dig_i,
   output logic [BCD_DIGIT_W-1:0] dig_o
);
   assign dig_o = (dig_i >= ADD3_THRESH) ? dig_i + BCD_DIGIT_W'(3) : dig_i;
endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD (shift-and-add-3), one bit per clock; result valid BIN_W cycles after accept.
// One conversion in flight: input stalls (in_ready=0) until the result is taken; result held while out_ready=0.
module bin_to_bcd_serial
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bin_to_bcd_serial_if.slave   bus
);
   localparam int ACC_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   // The accumulator drops bits off its top, so it must be able to hold 2**BIN_W-1.
   if (10**DIGITS < 2**BIN_W) begin : g_range_chk
      $error("bin_to_bcd_serial: DIGITS too small for BIN_W");
   end

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
   logic [ACC_W-1:0]   bcd_acc_q, bcd_acc_d;
   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   bcd_out_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      bcd_add3_digit u_add3 (
         .dig_i (bcd_acc_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dig_o (acc_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign bcd_acc_d = {acc_adj[ACC_W-2:0], bin_sr_q[BIN_W-1]};
   assign bin_sr_d  = bin_sr_q << 1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bin_sr_q    <= '0;
         bcd_acc_q   <= '0;
         bcd_out_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  bin_sr_q   <= bus.bin_in;
                  bcd_acc_q  <= '0;
                  cnt_q      <= '0;
                  state_q    <= S_SHIFT;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_SHIFT: begin
               bcd_acc_q <= bcd_acc_d;
               bin_sr_q  <= bin_sr_d;
               cnt_q     <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BIN_W - 1)) begin
                  bcd_out_q   <= bcd_acc_d;
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.bcd_out   = bcd_out_q;
   assign bus.busy      = busy_q;

endmodule
